multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 clk  input  1  Single clock; all state updates on rising edge.
REQ-002 reset  input  1  Asynchronous, active-low reset; low forces the FSM to IF immediately, independent of clk.
REQ-003 opcode  input  7  Opcode field of the external instruction register, stable from ID onward.
REQ-004 mem_ready  input  1  Memory completion strobe for the current read or write access.
REQ-005 alu_bcond  input  1  Branch-taken result from the ALU, valid in EX.
REQ-006 halt_req  input  1  High when register x17 == 10, sampled in ID.
REQ-007 pc_write  output  1  Load PC with the source chosen by pc_src at the next edge.
REQ-008 ir_write  output  1  Load the instruction register from memory dout.
REQ-009 i_or_d  output  1  Memory address select: 0 = PC, 1 = ALU result.
REQ-010 mem_read / mem_write  output  1 each  Memory access requests.
REQ-011 reg_write  output  1  Register file write enable.
REQ-012 wb_sel  output  2  Write-back data select: 0 = ALU, 1 = memory, 2 = PC+4.
REQ-013 pc_src  output  2  PC source: 0 = PC+4, 1 = PC+imm, 2 = (rs1+imm) & ~1.
REQ-014 alu_mode  output  2  ALU mode: 0 = add, 1 = decode by funct fields, 2 = branch compare.
REQ-015 state  output  3  Current state, for debug.
REQ-016 is_halted  output  1  Simulation finished.

Function
REQ-017 The FSM SHALL use states IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL return to IF at the next edge.
REQ-018 In IF, the block SHALL hold mem_read=1 and i_or_d=0, and stay in IF until mem_ready=1; in the mem_ready cycle it SHALL assert ir_write=1 and go to ID.
REQ-019 In ID, for ECALL (1110011) with halt_req=1, the next state SHALL be HALT.
REQ-020 In ID, for ECALL with halt_req=0, or for an unrecognised opcode, the block SHALL assert pc_write=1 with pc_src=0 and go to IF (treated as a NOP).
REQ-021 In ID, all other recognised opcodes SHALL go to EX.
REQ-022 In EX, R-type (0110011) and I-ALU (0010011) SHALL drive alu_mode=1 and go to WB.
REQ-023 In EX, LOAD (0000011) and STORE (0100011) SHALL drive alu_mode=0 and go to MEM.
REQ-024 In EX, BRANCH (1100011) SHALL drive alu_mode=2 and pc_write=1, with pc_src=1 if alu_bcond else 0, then go to IF.
REQ-025 In EX, JAL (1101111) and JALR (1100111) SHALL drive alu_mode=0 and go to WB.
REQ-026 In MEM, the block SHALL hold i_or_d=1 and mem_read=1 for LOAD, or i_or_d=1 and mem_write=1 for STORE, until mem_ready=1.
REQ-027 In the MEM mem_ready cycle, LOAD SHALL go to WB; STORE SHALL assert pc_write=1 with pc_src=0 and go to IF.
REQ-028 WB SHALL last one cycle and assert reg_write=1 and pc_write=1, then go to IF.
REQ-029 WB select values SHALL be: ALU ops wb_sel=0, pc_src=0; LOAD wb_sel=1, pc_src=0; JAL wb_sel=2, pc_src=1; JALR wb_sel=2, pc_src=2.
REQ-030 HALT SHALL be absorbing: is_halted=1, with every other output except state held at 0.
REQ-031 Outputs SHALL be combinational from state, opcode, mem_ready and alu_bcond; any output not named for a state SHALL be 0 in that state.
REQ-032 pc_write, reg_write, ir_write and mem_write SHALL each be asserted at most once per instruction.
REQ-033 With zero-wait memory (mem_ready tied high), latencies SHALL be: branch 3 cycles; R/I/JAL/JALR/STORE 4; LOAD 5; non-halting ECALL 2.
REQ-034 Each cycle with mem_ready=0 in IF or MEM SHALL add exactly one cycle of latency, with all outputs held stable.

Reset
REQ-035 While reset=0: state=IF, is_halted=0, and every other output SHALL be 0, even though state reads IF.
REQ-036 The first rising edge after reset rises SHALL see IF outputs (mem_read=1).
REQ-037 Asserting reset in any state, including HALT or mid-MEM wait, SHALL abort the instruction with no pc_write, reg_write or mem_write issued afterwards.

Verification
REQ-038 R-type, mem_ready=1 -> states 0,1,2,4,0; reg_write=1 and pc_write=1 only in the WB cycle; wb_sel=0.
REQ-039 LOAD with mem_ready low for 2 cycles in MEM -> 7 cycles total; mem_read and i_or_d=1 held through the wait; WB has wb_sel=1.
REQ-040 BRANCH with alu_bcond=1, then with alu_bcond=0 -> 3 cycles each; EX cycle has pc_src=1 and pc_src=0 respectively; reg_write never asserted.
REQ-041 JALR -> WB cycle has wb_sel=2, pc_src=2, reg_write=1 and pc_write=1.
REQ-042 ECALL with halt_req=1 -> state 5 and is_halted=1 from the next cycle, held for 100 cycles; ECALL with halt_req=0 -> 2 cycles, pc_src=0.
REQ-043 reset driven low mid-clock during a MEM STORE wait -> outputs 0 immediately with no write issued; after release, IF resumes.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Main control FSM for a multi-cycle RV32 datapath: sequences fetch, decode,
// execute, memory and write-back, and drives datapath enables and selects.
//
// state | meaning
// IF    | fetch: read memory at PC, load IR on mem_ready
// ID    | decode: choose EX, halt, or retire as a NOP
// EX    | execute: ALU op, address calc, or branch resolution
// MEM   | data memory access for LOAD/STORE, held until mem_ready
// WB    | register write-back and PC update
// HALT  | absorbing stop state after ECALL with halt_req
module multi_cycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_bcond,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] pc_src,
  output logic [1:0] alu_mode,
  output logic [2:0] state,
  output logic       is_halted
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  state_t state_q;
  state_t state_d;

  logic is_alu;
  logic is_load;
  logic is_store;
  logic is_branch;
  logic is_jal;
  logic is_jalr;
  logic is_ecall;
  logic is_known;

  assign is_alu    = (opcode == OP_R) || (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_ecall  = (opcode == OP_ECALL);
  assign is_known  = is_alu || is_load || is_store || is_branch ||
                     is_jal || is_jalr || is_ecall;

  logic       pc_write_c;
  logic       ir_write_c;
  logic       i_or_d_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic       reg_write_c;
  logic [1:0] wb_sel_c;
  logic [1:0] pc_src_c;
  logic [1:0] alu_mode_c;
  logic       is_halted_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = S_IF;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    i_or_d_c    = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    wb_sel_c    = 2'd0;
    pc_src_c    = 2'd0;
    alu_mode_c  = 2'd0;
    is_halted_c = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_ID;
        end else begin
          state_d = S_IF;
        end
      end

      S_ID: begin
        if (is_ecall && halt_req) begin
          state_d = S_HALT;
        end else if (is_ecall || !is_known) begin
          pc_write_c = 1'b1;
          state_d    = S_IF;
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        if (is_alu) begin
          alu_mode_c = 2'd1;
          state_d    = S_WB;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          alu_mode_c = 2'd2;
          pc_write_c = 1'b1;
          pc_src_c   = alu_bcond ? 2'd1 : 2'd0;
          state_d    = S_IF;
        end else if (is_jal || is_jalr) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end

      S_MEM: begin
        if (is_load) begin
          i_or_d_c   = 1'b1;
          mem_read_c = 1'b1;
          state_d    = mem_ready ? S_WB : S_MEM;
        end else if (is_store) begin
          i_or_d_c    = 1'b1;
          mem_write_c = 1'b1;
          if (mem_ready) begin
            pc_write_c = 1'b1;
            state_d    = S_IF;
          end else begin
            state_d = S_MEM;
          end
        end else begin
          state_d = S_IF;
        end
      end

      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        if (is_load) begin
          wb_sel_c = 2'd1;
        end else if (is_jal) begin
          wb_sel_c = 2'd2;
          pc_src_c = 2'd1;
        end else if (is_jalr) begin
          wb_sel_c = 2'd2;
          pc_src_c = 2'd2;
        end
        state_d = S_IF;
      end

      S_HALT: begin
        is_halted_c = 1'b1;
        state_d     = S_HALT;
      end

      default: state_d = S_IF;
    endcase
  end

  // Reset gates every control output so nothing fires while state reads IF.
  assign pc_write  = reset & pc_write_c;
  assign ir_write  = reset & ir_write_c;
  assign i_or_d    = reset & i_or_d_c;
  assign mem_read  = reset & mem_read_c;
  assign mem_write = reset & mem_write_c;
  assign reg_write = reset & reg_write_c;
  assign wb_sel    = reset ? wb_sel_c   : 2'd0;
  assign pc_src    = reset ? pc_src_c   : 2'd0;
  assign alu_mode  = reset ? alu_mode_c : 2'd0;
  assign is_halted = reset & is_halted_c;
  assign state     = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: each instruction pushes its
// per-cycle stimulus and expected outputs, the runner pops and compares them.
module tb_multi_cycle_control;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2;
  localparam logic [2:0] ST_MEM = 3'd3, ST_WB = 3'd4, ST_HALT = 3'd5;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       alu_bcond;
  logic       halt_req;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic [1:0] wb_sel, pc_src, alu_mode;
  logic [2:0] state;
  logic       is_halted;

  multi_cycle_control dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .alu_bcond (alu_bcond),
    .halt_req  (halt_req),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .i_or_d    (i_or_d),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .pc_src    (pc_src),
    .alu_mode  (alu_mode),
    .state     (state),
    .is_halted (is_halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, wb_sel, pc_src, alu_mode, is_halted}
  logic [12:0] outs;
  assign outs = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
                 wb_sel, pc_src, alu_mode, is_halted};

  typedef struct packed {
    logic [2:0]  st;
    logic        mr;
    logic        bc;
    logic        hr;
    logic [12:0] outs;
  } rec_t;

  rec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [12:0] ov(input logic pw, input logic iw, input logic iod,
                                     input logic mrd, input logic mw, input logic rw,
                                     input logic [1:0] wb, input logic [1:0] pcs,
                                     input logic [1:0] alu, input logic h);
    return {pw, iw, iod, mrd, mw, rw, wb, pcs, alu, h};
  endfunction

  task automatic push(input logic [2:0] st, input logic mr, input logic bc,
                      input logic hr, input logic [12:0] o);
    rec_t r;
    r.st   = st;
    r.mr   = mr;
    r.bc   = bc;
    r.hr   = hr;
    r.outs = o;
    sb.push_back(r);
  endtask

  // Entered at posedge+1; each record is checked on the falling edge.
  task automatic run_sb(input string name);
    rec_t r;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      mem_ready = r.mr;
      alu_bcond = r.bc;
      halt_req  = r.hr;
      #4;
      check({name, "_state"}, 32'(state), 32'(r.st));
      check({name, "_outs"}, 32'(outs), 32'(r.outs));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_if(input int waits);
    repeat (waits) push(ST_IF, 1'b0, rb(), rb(), ov(0,0,0,1,0,0,2'd0,2'd0,2'd0,0));
    push(ST_IF, 1'b1, rb(), rb(), ov(0,1,0,1,0,0,2'd0,2'd0,2'd0,0));
  endtask

  task automatic instr(input string name, input logic [6:0] op, input int ifw,
                       input int memw, input logic bc, input logic hr);
    logic [12:0] z;
    z = ov(0,0,0,0,0,0,2'd0,2'd0,2'd0,0);
    opcode = op;
    push_if(ifw);
    if (op == OP_ECALL && hr) begin
      push(ST_ID, rb(), rb(), 1'b1, z);
      repeat (100) push(ST_HALT, rb(), rb(), rb(), ov(0,0,0,0,0,0,2'd0,2'd0,2'd0,1));
    end else if (op == OP_ECALL || op == OP_BAD) begin
      push(ST_ID, rb(), rb(), 1'b0, ov(1,0,0,0,0,0,2'd0,2'd0,2'd0,0));
    end else begin
      push(ST_ID, rb(), rb(), 1'b0, z);
      case (op)
        OP_R, OP_I: begin
          push(ST_EX, rb(), rb(), rb(), ov(0,0,0,0,0,0,2'd0,2'd0,2'd1,0));
          push(ST_WB, rb(), rb(), rb(), ov(1,0,0,0,0,1,2'd0,2'd0,2'd0,0));
        end
        OP_LOAD: begin
          push(ST_EX, rb(), rb(), rb(), z);
          repeat (memw) push(ST_MEM, 1'b0, rb(), rb(), ov(0,0,1,1,0,0,2'd0,2'd0,2'd0,0));
          push(ST_MEM, 1'b1, rb(), rb(), ov(0,0,1,1,0,0,2'd0,2'd0,2'd0,0));
          push(ST_WB, rb(), rb(), rb(), ov(1,0,0,0,0,1,2'd1,2'd0,2'd0,0));
        end
        OP_STORE: begin
          push(ST_EX, rb(), rb(), rb(), z);
          repeat (memw) push(ST_MEM, 1'b0, rb(), rb(), ov(0,0,1,0,1,0,2'd0,2'd0,2'd0,0));
          push(ST_MEM, 1'b1, rb(), rb(), ov(1,0,1,0,1,0,2'd0,2'd0,2'd0,0));
        end
        OP_BRANCH: begin
          push(ST_EX, rb(), bc, rb(), ov(1,0,0,0,0,0,2'd0,{1'b0, bc},2'd2,0));
        end
        OP_JAL: begin
          push(ST_EX, rb(), rb(), rb(), z);
          push(ST_WB, rb(), rb(), rb(), ov(1,0,0,0,0,1,2'd2,2'd1,2'd0,0));
        end
        OP_JALR: begin
          push(ST_EX, rb(), rb(), rb(), z);
          push(ST_WB, rb(), rb(), rb(), ov(1,0,0,0,0,1,2'd2,2'd2,2'd0,0));
        end
        default: ;
      endcase
    end
    run_sb(name);
  endtask

  initial begin
    reset     = 1'b0;
    opcode    = 7'd0;
    mem_ready = 1'b1;
    alu_bcond = 1'b0;
    halt_req  = 1'b0;

    #1;
    check("rst_state", 32'(state), 32'(ST_IF));
    check("rst_outs", 32'(outs), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_state", 32'(state), 32'(ST_IF));
    check("rst_hold_outs", 32'(outs), 32'd0);

    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("rel_if_outs", 32'(outs), 32'(ov(0,0,0,1,0,0,2'd0,2'd0,2'd0,0)));
    @(posedge clk);
    #1;
    check("rel_first_edge_state", 32'(state), 32'(ST_IF));

    instr("rtype",   OP_R,      0, 0, 1'b0, 1'b0);
    instr("ialu",    OP_I,      1, 0, 1'b0, 1'b0);
    instr("load_w2", OP_LOAD,   0, 2, 1'b0, 1'b0);
    instr("load_w0", OP_LOAD,   0, 0, 1'b0, 1'b0);
    instr("store",   OP_STORE,  0, 0, 1'b0, 1'b0);
    instr("store_w", OP_STORE,  2, 1, 1'b0, 1'b0);
    instr("br_t",    OP_BRANCH, 0, 0, 1'b1, 1'b0);
    instr("br_nt",   OP_BRANCH, 0, 0, 1'b0, 1'b0);
    instr("jal",     OP_JAL,    0, 0, 1'b0, 1'b0);
    instr("jalr",    OP_JALR,   0, 0, 1'b0, 1'b0);
    instr("ecall_nh", OP_ECALL, 0, 0, 1'b0, 1'b0);
    instr("bad_op",  OP_BAD,    0, 0, 1'b0, 1'b0);

    // Reset in the middle of a STORE memory wait.
    opcode = OP_STORE;
    push_if(0);
    push(ST_ID, rb(), rb(), 1'b0, ov(0,0,0,0,0,0,2'd0,2'd0,2'd0,0));
    push(ST_EX, rb(), rb(), rb(), ov(0,0,0,0,0,0,2'd0,2'd0,2'd0,0));
    push(ST_MEM, 1'b0, rb(), rb(), ov(0,0,1,0,1,0,2'd0,2'd0,2'd0,0));
    run_sb("st_pre_rst");
    mem_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("st_rst_state", 32'(state), 32'(ST_IF));
    check("st_rst_outs", 32'(outs), 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("st_rst_hold_outs", 32'(outs), 32'd0);
    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("st_rel_state", 32'(state), 32'(ST_IF));
    check("st_rel_outs", 32'(outs), 32'(ov(0,0,0,1,0,0,2'd0,2'd0,2'd0,0)));
    @(posedge clk);
    #1;
    instr("after_rst", OP_R, 0, 0, 1'b0, 1'b0);

    instr("ecall_halt", OP_ECALL, 0, 0, 1'b0, 1'b1);

    #2;
    reset = 1'b0;
    #1;
    check("halt_rst_state", 32'(state), 32'(ST_IF));
    check("halt_rst_outs", 32'(outs), 32'd0);
    mem_ready = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    instr("after_halt", OP_JAL, 1, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
